// File: rtl/receptor_sequencia_pkg.sv
// Shared constants for the sequence receiver: code sequence, segment patterns
// and the match-index encoding.
package receptor_sequencia_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned DIG_W    = 4;
  localparam int unsigned CODE_LEN = 9;

  // Match index: number of code symbols already matched.
  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } indice_e;

  // Active-low segment patterns, same bit order as the display decoder.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Code 3,1,8,0,5,7,7,5,2; element 0 is the first symbol.
  localparam logic [CODE_LEN-1:0][DIG_W-1:0] CODE = {
    4'd2, 4'd5, 4'd7, 4'd7, 4'd5, 4'd0, 4'd8, 4'd1, 4'd3
  };

  function automatic logic [DIG_W-1:0] code_at(input indice_e idx);
    return CODE[idx];
  endfunction

  function automatic indice_e next_index(input indice_e idx);
    return indice_e'(4'(idx) + 4'd1);
  endfunction

endpackage

// File: rtl/receptor_sequencia_decodificador_7seg.sv
// Combinational inverse of the seven-segment encoder: pattern to digit,
// flagging the blank pattern and any pattern that is not a digit.
module decodificador_7seg
  import receptor_sequencia_pkg::*;
(
  input  logic [SEG_W-1:0] segmentos_i,
  output logic [DIG_W-1:0] digito_c_o,
  output logic             branco_c_o,
  output logic             invalido_c_o
);

  always_comb begin
    digito_c_o   = '0;
    branco_c_o   = 1'b0;
    invalido_c_o = 1'b0;
    case (segmentos_i)
      SEG_0:     digito_c_o = 4'd0;
      SEG_1:     digito_c_o = 4'd1;
      SEG_2:     digito_c_o = 4'd2;
      SEG_3:     digito_c_o = 4'd3;
      SEG_4:     digito_c_o = 4'd4;
      SEG_5:     digito_c_o = 4'd5;
      SEG_6:     digito_c_o = 4'd6;
      SEG_7:     digito_c_o = 4'd7;
      SEG_8:     digito_c_o = 4'd8;
      SEG_9:     digito_c_o = 4'd9;
      SEG_BLANK: branco_c_o = 1'b1;
      default:   invalido_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/receptor_sequencia.sv
// Sequence receiver: matches strobed seven-segment symbols against a fixed
// code, abandoning partial progress after TIMEOUT quiet cycles.
module receptor_sequencia
  import receptor_sequencia_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEG_W-1:0] segmentos,
  input  logic             amostra,
  output logic [DIG_W-1:0] digito,
  output logic             valido,
  output logic [DIG_W-1:0] progresso,
  output logic             acerto,
  output logic             erro
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [DIG_W-1:0] dec_digito;
  logic             dec_branco;
  logic             dec_invalido;

  indice_e          state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [DIG_W-1:0] digito_q, digito_d;
  logic             valido_q, valido_d;
  logic             acerto_q, acerto_d;
  logic             erro_q,   erro_d;

  decodificador_7seg u_dec (
    .segmentos_i  (segmentos),
    .digito_c_o   (dec_digito),
    .branco_c_o   (dec_branco),
    .invalido_c_o (dec_invalido)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S0;
      cnt_q    <= '0;
      digito_q <= '0;
      valido_q <= 1'b0;
      acerto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digito_q <= digito_d;
      valido_q <= valido_d;
      acerto_q <= acerto_d;
      erro_q   <= erro_d;
    end
  end

  // A strobe always takes priority over timeout expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digito_d = digito_q;
    valido_d = valido_q;
    acerto_d = 1'b0;
    erro_d   = 1'b0;

    if (amostra) begin
      cnt_d = '0;
      if (dec_invalido) begin
        erro_d   = 1'b1;
        state_d  = S0;
        valido_d = 1'b0;
      end else if (dec_branco) begin
        state_d  = S0;
        valido_d = 1'b0;
      end else begin
        digito_d = dec_digito;
        valido_d = 1'b1;
        if (dec_digito == code_at(state_q)) begin
          if (state_q == S8) begin
            state_d  = S0;
            acerto_d = 1'b1;
          end else begin
            state_d = next_index(state_q);
          end
        end else begin
          // A wrong digit that is itself the first code symbol restarts at S1.
          erro_d  = 1'b1;
          state_d = (dec_digito == code_at(S0)) ? S1 : S0;
        end
      end
    end else if (state_q == S0) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      erro_d  = 1'b1;
      state_d = S0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign digito    = digito_q;
  assign valido    = valido_q;
  assign progresso = DIG_W'(state_q);
  assign acerto    = acerto_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_receptor_sequencia.sv
// Self-checking bench for receptor_sequencia: per-cycle comparison against a
// behavioural model plus hand-computed literal expectations.
module tb_receptor_sequencia;

  localparam int TO = 20;

  localparam logic [6:0] PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] BAD   = 7'b0101010;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       amostra = 1'b0;
  logic [6:0] segmentos = 7'b1111111;
  logic [3:0] digito;
  logic [3:0] progresso;
  logic       valido;
  logic       acerto;
  logic       erro;

  receptor_sequencia #(.TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .segmentos (segmentos),
    .amostra   (amostra),
    .digito    (digito),
    .valido    (valido),
    .progresso (progresso),
    .acerto    (acerto),
    .erro      (erro)
  );

  always #5 clock = ~clock;

  int code [9] = '{3, 1, 8, 0, 5, 7, 7, 5, 2};

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: how many code symbols are matched, and how long
  // the receiver has been waiting with partial progress.
  int m_idx   = 0;
  int m_quiet = 0;
  int m_dig   = 0;
  bit m_val   = 1'b0;
  bit m_ac    = 1'b0;
  bit m_er    = 1'b0;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == PAT[i]) return i;
    if (s == BLANK) return 10;
    return -1;
  endfunction

  always @(posedge clock) begin : model
    int d;
    int nidx;
    bit ac;
    bit er;
    if (!reset) begin
      m_idx   <= 0;
      m_quiet <= 0;
      m_dig   <= 0;
      m_val   <= 1'b0;
      m_ac    <= 1'b0;
      m_er    <= 1'b0;
    end else begin
      nidx = m_idx;
      ac   = 1'b0;
      er   = 1'b0;
      if (amostra) begin
        d = lookup(segmentos);
        if (d < 0) begin
          er = 1'b1;
          nidx = 0;
          m_val <= 1'b0;
        end else if (d == 10) begin
          nidx = 0;
          m_val <= 1'b0;
        end else begin
          m_dig <= d;
          m_val <= 1'b1;
          if (d == code[m_idx]) begin
            if (m_idx == 8) begin
              nidx = 0;
              ac = 1'b1;
            end else begin
              nidx = m_idx + 1;
            end
          end else begin
            er = 1'b1;
            nidx = (d == code[0]) ? 1 : 0;
          end
        end
        m_quiet <= 0;
      end else if (m_idx == 0) begin
        m_quiet <= 0;
      end else begin
        if (m_quiet >= TO - 1) begin
          er = 1'b1;
          nidx = 0;
        end
        m_quiet <= m_quiet + 1;
      end
      m_idx <= nidx;
      m_ac  <= ac;
      m_er  <= er;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(negedge clock);
    if (chk_en) begin
      check("model.digito", int'(digito), m_dig);
      check("model.valido", int'(valido), int'(m_val));
      check("model.progresso", int'(progresso), m_idx);
      check("model.acerto", int'(acerto), int'(m_ac));
      check("model.erro", int'(erro), int'(m_er));
      check("pulses_exclusive", int'(acerto & erro), 0);
    end
  endtask

  task automatic strobe(input logic [6:0] seg);
    segmentos = seg;
    amostra   = 1'b1;
    tick();
    amostra   = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    check("reset.digito", int'(digito), 0);
    check("reset.valido", int'(valido), 0);
    check("reset.progresso", int'(progresso), 0);
    check("reset.pulses", int'({acerto, erro}), 0);
    reset = 1'b1;
    tick();

    // Full code: progress 1..8, then acerto on the final symbol.
    for (int i = 0; i < 8; i++) begin
      strobe(PAT[code[i]]);
      check("seq.progresso", int'(progresso), i + 1);
      check("seq.erro", int'(erro), 0);
    end
    strobe(PAT[2]);
    check("seq.acerto", int'(acerto), 1);
    check("seq.final_progresso", int'(progresso), 0);
    check("seq.final_digito", int'(digito), 2);
    tick();
    check("seq.acerto_one_cycle", int'(acerto), 0);

    // Wrong digit, then a repeated first symbol.
    strobe(PAT[3]);
    strobe(PAT[1]);
    strobe(PAT[8]);
    strobe(PAT[4]);
    check("wrong.erro", int'(erro), 1);
    check("wrong.progresso", int'(progresso), 0);
    strobe(PAT[3]);
    check("rep3.first_erro", int'(erro), 0);
    strobe(PAT[3]);
    check("rep3.second_erro", int'(erro), 1);
    check("rep3.progresso", int'(progresso), 1);
    tick();

    // Blank resets silently; invalid pattern resets with erro.
    strobe(BLANK);
    strobe(PAT[3]);
    strobe(PAT[1]);
    check("blank.pre_progresso", int'(progresso), 2);
    strobe(BLANK);
    check("blank.erro", int'(erro), 0);
    check("blank.progresso", int'(progresso), 0);
    check("blank.valido", int'(valido), 0);
    check("blank.digito", int'(digito), 1);
    strobe(BAD);
    check("bad.erro", int'(erro), 1);
    check("bad.valido", int'(valido), 0);
    check("bad.digito", int'(digito), 1);
    tick();

    // Timeout expires on the 20th quiet cycle.
    strobe(PAT[3]);
    repeat (TO - 1) tick();
    check("idle.progresso_held", int'(progresso), 1);
    check("idle.no_erro", int'(erro), 0);
    tick();
    check("timeout.erro", int'(erro), 1);
    check("timeout.progresso", int'(progresso), 0);
    tick();
    check("timeout.erro_one_cycle", int'(erro), 0);

    // A strobe in the expiry cycle wins over the timeout.
    strobe(PAT[3]);
    repeat (TO - 1) tick();
    strobe(PAT[1]);
    check("expiry_strobe.erro", int'(erro), 0);
    check("expiry_strobe.progresso", int'(progresso), 2);

    // Reset at index 5 together with a strobe for the next symbol.
    strobe(BLANK);
    for (int i = 0; i < 5; i++) strobe(PAT[code[i]]);
    check("prereset.progresso", int'(progresso), 5);
    reset     = 1'b0;
    segmentos = PAT[7];
    amostra   = 1'b1;
    tick();
    check("rst.progresso", int'(progresso), 0);
    check("rst.digito", int'(digito), 0);
    check("rst.valido", int'(valido), 0);
    check("rst.acerto", int'(acerto), 0);
    check("rst.erro", int'(erro), 0);
    reset   = 1'b1;
    amostra = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
